// File: rtl/vga_timing_out.sv
// 640x480@60 VGA timing generator and TinyVGA PMOD pin packer.
// Ports: clk, rst_n, en; x/y/line_start/frame_start/frame_cnt out; rgb_in in; uo_out pins.
module vga_timing_out #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int PIPE_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt,
  input  logic [5:0] rgb_in,
  output logic [7:0] uo_out
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_LO   = H_VISIBLE + H_FRONT;
  localparam int HS_HI   = HS_LO + H_SYNC - 1;
  localparam int VS_LO   = V_VISIBLE + V_FRONT;
  localparam int VS_HI   = VS_LO + V_SYNC - 1;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  localparam sync_t IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

  logic  x_last;
  logic  y_last;
  sync_t raw;
  sync_t dly;
  logic [5:0] rgb_m;

  assign x_last = (x == 10'(H_TOTAL - 1));
  assign y_last = (y == 10'(V_TOTAL - 1));

  assign line_start  = (x == 10'd0);
  assign frame_start = (x == 10'd0) && (y == 10'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= '0;
      y         <= '0;
      frame_cnt <= '0;
    end else if (en) begin
      if (x_last) begin
        x <= '0;
        if (y_last) begin
          y         <= '0;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          y <= y + 10'd1;
        end
      end else begin
        x <= x + 10'd1;
      end
    end
  end

  assign raw.de = (x < 10'(H_VISIBLE)) &&
                  (y < 10'(V_VISIBLE));
  assign raw.hs = !((x >= 10'(HS_LO)) &&
                    (x <= 10'(HS_HI)));
  assign raw.vs = !((y >= 10'(VS_LO)) &&
                    (y <= 10'(VS_HI)));

  // Sync/blank ride alongside the renderer's pipeline
  if (PIPE_DEPTH == 0) begin : g_pass
    assign dly = raw;
  end else begin : g_pipe
    sync_t stg [PIPE_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < PIPE_DEPTH; i++)
          stg[i] <= IDLE;
      end else if (en) begin
        stg[0] <= raw;
        for (int i = 1; i < PIPE_DEPTH; i++)
          stg[i] <= stg[i-1];
      end
    end

    assign dly = stg[PIPE_DEPTH-1];
  end

  // Blanked colour: rgb_in is a don't-care outside the active area
  assign rgb_m = dly.de ? rgb_in : 6'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uo_out <= 8'h88;
    end else if (en) begin
      uo_out <= {dly.hs, rgb_m[0], rgb_m[2], rgb_m[4],
                 dly.vs, rgb_m[1], rgb_m[3], rgb_m[5]};
    end
  end

endmodule
